mem_responder: RTL and testbench



---
 rtl/mem_resp_pkg.sv | 13 +
 rtl/word_store.sv | 24 ++
 rtl/mem_responder.sv | 105 ++++++++++
 tb/tb_mem_responder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory-side responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

  typedef enum logic {OP_READ, OP_WRITE} op_t;

  function automatic int unsigned calc_read_beats(input int unsigned read_size,
                                                  input int unsigned word_size);
    return read_size / word_size;
  endfunction

endpackage

// File: rtl/word_store.sv
// Word-organised local store: synchronous write, combinational read.
module word_store #(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [WORD_SIZE-1:0] rdata
);

  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Serves one read or write at a time: single-cycle writes, multi-beat line reads,
// level-held request / held-until-drop completion handshake.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_SIZE       = 16,
  parameter int unsigned WRITE_DATA_SIZE = 32,
  parameter int unsigned READ_DATA_SIZE  = 512,
  parameter int unsigned WORD_SIZE       = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       read_en,
  input  logic [ADDR_SIZE-1:0]       read_addr,
  output logic [READ_DATA_SIZE-1:0]  read_data,
  output logic                       read_valid,
  input  logic                       write_en,
  input  logic [ADDR_SIZE-1:0]       write_addr,
  input  logic [WRITE_DATA_SIZE-1:0] write_data,
  output logic                       write_done
);

  localparam int unsigned READ_BEATS = calc_read_beats(READ_DATA_SIZE, WORD_SIZE);
  localparam int unsigned BEAT_W     = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(READ_BEATS - 1);

  if (WRITE_DATA_SIZE != WORD_SIZE) begin : g_bad_write_width
    $error("WRITE_DATA_SIZE must equal WORD_SIZE");
  end
  if ((READ_DATA_SIZE % WORD_SIZE) != 0 || READ_BEATS == 0) begin : g_bad_read_width
    $error("READ_DATA_SIZE must be a non-zero multiple of WORD_SIZE");
  end

  state_t               state_q;
  op_t                  op_q;
  logic [BEAT_W-1:0]    beat_q;
  logic [ADDR_SIZE-1:0] base_q;

  logic                 store_we;
  logic [ADDR_SIZE-1:0] store_raddr;
  logic [WORD_SIZE-1:0] store_rdata;

  // Writes commit on the accept edge itself, so the store write enable is combinational.
  assign store_we    = (state_q == IDLE) && write_en;
  assign store_raddr = base_q + ADDR_SIZE'(beat_q);

  word_store #(
    .ADDR_SIZE(ADDR_SIZE),
    .WORD_SIZE(WORD_SIZE)
  ) u_word_store (
    .clk  (clk),
    .we   (store_we),
    .waddr(write_addr),
    .wdata(write_data),
    .raddr(store_raddr),
    .rdata(store_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_READ;
      beat_q     <= '0;
      base_q     <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      write_done <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (write_en) begin
            op_q       <= OP_WRITE;
            write_done <= 1'b1;
            state_q    <= ACK;
          end else if (read_en) begin
            op_q    <= OP_READ;
            base_q  <= read_addr;
            beat_q  <= '0;
            state_q <= READ;
          end
        end
        READ: begin
          read_data[beat_q*WORD_SIZE +: WORD_SIZE] <= store_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_q     <= '0;
            read_valid <= 1'b1;
            state_q    <= ACK;
          end else begin
            beat_q <= beat_q + 1'b1;
          end
        end
        ACK: begin
          // Only the request being served can release the handshake.
          if ((op_q == OP_READ && !read_en) || (op_q == OP_WRITE && !write_en)) begin
            read_valid <= 1'b0;
            write_done <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a word model predicts each line read back.
module tb_mem_responder;

  logic         clk;
  logic         rst_n;
  logic         read_en;
  logic [15:0]  read_addr;
  logic [511:0] read_data;
  logic         read_valid;
  logic         write_en;
  logic [15:0]  write_addr;
  logic [31:0]  write_data;
  logic         write_done;

  mem_responder u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .read_en   (read_en),
    .read_addr (read_addr),
    .read_data (read_data),
    .read_valid(read_valid),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_done(write_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] line;
    logic [511:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model[logic [15:0]];
  int          checks_cnt = 0;
  int          errors_cnt = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] want);
    checks_cnt++;
    if (got !== want) begin
      errors_cnt++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Expected line from the model; unwritten words are masked out.
  function automatic exp_t build_exp(input logic [15:0] base);
    exp_t e;
    e.line = '0;
    e.mask = '0;
    for (int i = 0; i < 16; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      if (model.exists(a)) begin
        e.line[i*32 +: 32] = model[a];
        e.mask[i*32 +: 32] = '1;
      end
    end
    return e;
  endfunction

  // Counts falling edges until the selected completion flag is seen (bounded).
  task automatic wait_flag(input bit is_write, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_write ? write_done : read_valid) && n < 200);
  endtask

  task automatic check_line(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_q_empty"}, 512'd1, 512'd0);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, read_data & e.mask, e.line);
    end
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input string tag);
    int n;
    @(negedge clk);
    write_addr = addr;
    write_data = data;
    write_en   = 1'b1;
    wait_flag(1'b1, n);
    check_eq({tag, "_lat"}, 512'(n), 512'd1);
    model[addr] = data;
    write_en = 1'b0;
    @(negedge clk);
    check_eq({tag, "_drop"}, 512'(write_done), 512'd0);
  endtask

  task automatic do_read(input logic [15:0] addr, input string tag);
    int n;
    exp_q.push_back(build_exp(addr));
    @(negedge clk);
    read_addr = addr;
    read_en   = 1'b1;
    wait_flag(1'b0, n);
    check_eq({tag, "_lat"}, 512'(n), 512'd17);
    check_line({tag, "_data"});
    read_en = 1'b0;
    @(negedge clk);
    check_eq({tag, "_drop"}, 512'(read_valid), 512'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && read_valid && write_done) check_eq("excl", 512'd1, 512'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; read_en = 1'b0; write_en = 1'b0;
    read_addr = '0; write_addr = '0; write_data = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 512'(read_valid), 512'd0);
    check_eq("rst_done", 512'(write_done), 512'd0);
    check_eq("rst_data", read_data, 512'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) do_write(16'h0100 + 16'(i), 32'(i), "pre_line");
    do_read(16'h0100, "rd_line");
    check_eq("rd_line_w0", 512'(read_data[31:0]), 512'h0);
    check_eq("rd_line_w15", 512'(read_data[511:480]), 512'hF);

    do_write(16'h0010, 32'hDEADBEEF, "wr_single");
    do_read(16'h0010, "rd_after_wr");
    check_eq("rd_after_wr_w0", 512'(read_data[31:0]), 512'hDEADBEEF);

    for (int i = 0; i < 16; i++)
      do_write(16'hFFF8 + 16'(i), 32'hA5000000 | 32'(i * 3 + 1), "pre_wrap");
    do_read(16'hFFF8, "rd_wrap");
    check_eq("rd_wrap_w8", 512'(read_data[287:256]), 512'hA5000019);

    // Both requests together: write first, read follows after write_en drops.
    @(negedge clk);
    write_addr = 16'h0020; write_data = 32'h12345678; read_addr = 16'h0020;
    write_en = 1'b1; read_en = 1'b1;
    model[16'h0020] = 32'h12345678;
    exp_q.push_back(build_exp(16'h0020));
    wait_flag(1'b1, n);
    check_eq("both_wr_lat", 512'(n), 512'd1);
    check_eq("both_no_valid", 512'(read_valid), 512'd0);
    write_en = 1'b0;
    wait_flag(1'b0, n);
    check_eq("both_rd_lat", 512'(n), 512'd18);
    check_line("both_rd_data");
    check_eq("both_rd_w0", 512'(read_data[31:0]), 512'h12345678);
    read_en = 1'b0;
    @(negedge clk);

    // Write raised at beat 5 of a read.
    exp_q.push_back(build_exp(16'h0100));
    @(negedge clk);
    read_addr = 16'h0100; read_en = 1'b1;
    repeat (6) @(negedge clk);
    write_addr = 16'h0030; write_data = 32'hCAFEF00D; write_en = 1'b1;
    wait_flag(1'b0, n);
    check_eq("mid_rd_lat", 512'(n), 512'd11);
    check_line("mid_rd_data");
    check_eq("mid_no_done", 512'(write_done), 512'd0);
    read_en = 1'b0;
    @(negedge clk);
    check_eq("mid_valid_fall", 512'(read_valid), 512'd0);
    check_eq("mid_done_wait", 512'(write_done), 512'd0);
    @(negedge clk);
    check_eq("mid_done_rise", 512'(write_done), 512'd1);
    model[16'h0030] = 32'hCAFEF00D;
    write_en = 1'b0;
    @(negedge clk);
    check_eq("mid_done_fall", 512'(write_done), 512'd0);
    do_read(16'h0030, "mid_rd_back");

    // Reset at beat 8 aborts the read.
    @(negedge clk);
    read_addr = 16'h0100; read_en = 1'b1;
    repeat (9) @(negedge clk);
    check_eq("abort_pre_valid", 512'(read_valid), 512'd0);
    rst_n = 1'b0;
    #1;
    check_eq("abort_valid", 512'(read_valid), 512'd0);
    check_eq("abort_done", 512'(write_done), 512'd0);
    check_eq("abort_data", read_data, 512'd0);
    read_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(16'h0100, "rd_reissue");

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
